// File: rtl/difftest_step_pkg.sv
// Shared types and constants for the difftest step scheduler.
package difftest_step_pkg;

  typedef enum logic [1:0] {
    ACCUM     = 2'd0,
    ISSUE     = 2'd1,
    HALT_PEND = 2'd2,
    HALT      = 2'd3
  } step_state_e;

  // Largest accumulator value that can still absorb one full cycle of steps
  // from every core without wrapping.
  function automatic int unsigned stall_margin(input int unsigned acc_w,
                                               input int unsigned num_core,
                                               input int unsigned step_w);
    return ((32'd1 << acc_w) - 32'd1) - num_core * ((32'd1 << step_w) - 32'd1);
  endfunction

endpackage

// File: rtl/difftest_step_sum.sv
// Combinational reduction of the packed per-core step counts into one total.
module difftest_step_sum
  import difftest_step_pkg::*;
#(
  parameter int NUM_CORE = 2,
  parameter int STEP_W   = 8,
  parameter int ACC_W    = 16
) (
  input  logic [NUM_CORE*STEP_W-1:0] i_core_step,
  output logic [ACC_W-1:0]           o_sum
);

  // NOTE: default the output before the loop so no latch is inferred.
  always_comb begin
    o_sum = '0;
    for (int i = 0; i < NUM_CORE; i++) begin
      o_sum = o_sum + ACC_W'(i_core_step[i*STEP_W +: STEP_W]);
    end
  end

endmodule

// File: rtl/difftest_step_scheduler.sv
// Batches per-core commit steps into one host step request with overflow stall
// and result-driven halt. Optional idle flush: DIFFTEST_STEP_TIMEOUT_EN.
module difftest_step_scheduler
  import difftest_step_pkg::*;
#(
  parameter int NUM_CORE     = 2,
  parameter int STEP_W       = 8,
  parameter int ACC_W        = 16,
  parameter int BATCH_THRESH = 64,
  parameter int TIMEOUT      = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CORE*STEP_W-1:0] core_step,
  input  logic [7:0]                 simv_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_step,
  output logic                       stall,
  output logic                       halted,
  output logic [7:0]                 result_code
);

  localparam logic [ACC_W-1:0] STALL_MARGIN =
    ACC_W'(stall_margin(ACC_W, NUM_CORE, STEP_W));

  step_state_e      r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_out_step;
  logic             r_out_valid;
  logic             r_stall;
  logic             r_halted;
  logic [7:0]       r_result_code;

  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_over;
  logic             w_result_nz;
  logic             w_tmo_fire;
  logic             w_flush;

  difftest_step_sum #(
    .NUM_CORE (NUM_CORE),
    .STEP_W   (STEP_W),
    .ACC_W    (ACC_W)
  ) u_sum (
    .i_core_step (core_step),
    .o_sum       (w_sum)
  );

  assign w_acc_nxt   = r_acc + (r_stall ? '0 : w_sum);
  assign w_over      = w_acc_nxt > STALL_MARGIN;
  assign w_result_nz = simv_result != 8'd0;
  assign w_flush     = (r_state == ACCUM) && !w_result_nz &&
                       ((w_acc_nxt >= ACC_W'(BATCH_THRESH)) || w_tmo_fire);

`ifdef DIFFTEST_STEP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  assign w_tmo_fire = r_tmo_cnt == TMO_W'(TIMEOUT);

  // Counts idle ACCUM cycles holding a residual; any other situation restarts it.
  always_ff @(posedge clock) begin
    if (reset || w_flush || r_state != ACCUM) begin
      r_tmo_cnt <= '0;
    end else if (r_acc != '0) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end
`else
  // No idle flush in this build; residual steps wait for the threshold.
  assign w_tmo_fire = 1'b0 & (TIMEOUT != 0);
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ACCUM;
      r_acc         <= '0;
      r_out_step    <= '0;
      r_out_valid   <= 1'b0;
      r_stall       <= 1'b0;
      r_halted      <= 1'b0;
      r_result_code <= 8'd0;
    end else begin
      if (!r_halted && w_result_nz) begin
        r_halted      <= 1'b1;
        r_result_code <= simv_result;
      end

      case (r_state)
        ACCUM: begin
          if (w_result_nz) begin
            r_state <= HALT;
            r_acc   <= '0;
            r_stall <= 1'b1;
          end else if (w_flush) begin
            r_out_step  <= w_acc_nxt;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_stall     <= 1'b0;
            r_state     <= ISSUE;
          end else begin
            r_acc   <= w_acc_nxt;
            r_stall <= w_over;
          end
        end

        ISSUE: begin
          r_acc <= w_acc_nxt;
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_result_nz) begin
              r_state <= HALT;
              r_acc   <= '0;
              r_stall <= 1'b1;
            end else begin
              r_state <= ACCUM;
              r_stall <= w_over;
            end
          end else if (w_result_nz) begin
            r_state <= HALT_PEND;
            r_stall <= 1'b1;
          end else begin
            r_stall <= w_over;
          end
        end

        HALT_PEND: begin
          r_stall <= 1'b1;
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_state     <= HALT;
          end
        end

        HALT: begin
          r_acc       <= '0;
          r_out_valid <= 1'b0;
          r_stall     <= 1'b1;
        end

        default: r_state <= ACCUM;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign out_step    = r_out_step;
  assign stall       = r_stall;
  assign halted      = r_halted;
  assign result_code = r_result_code;

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Directed-vector bench for difftest_step_scheduler with hand-computed expectations.
module tb_difftest_step_scheduler;

  localparam int NUM_CORE = 2;
  localparam int STEP_W   = 8;
  localparam int ACC_W    = 16;

  logic                       clock = 1'b0;
  logic                       reset;
  logic [NUM_CORE*STEP_W-1:0] core_step;
  logic [7:0]                 simv_result;
  logic                       out_valid;
  logic                       out_ready;
  logic [ACC_W-1:0]           out_step;
  logic                       stall;
  logic                       halted;
  logic [7:0]                 result_code;

  int n_vec = 0;
  int n_bad = 0;

  difftest_step_scheduler #(
    .NUM_CORE     (NUM_CORE),
    .STEP_W       (STEP_W),
    .ACC_W        (ACC_W),
    .BATCH_THRESH (64),
    .TIMEOUT      (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .core_step   (core_step),
    .simv_result (simv_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_step    (out_step),
    .stall       (stall),
    .halted      (halted),
    .result_code (result_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic steps(input logic [7:0] c1, input logic [7:0] c0);
    core_step = {c1, c0};
  endtask

  initial begin
    int  n;
    bit  seen;

    reset       = 1'b1;
    core_step   = '0;
    simv_result = 8'd0;
    out_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_valid",  out_valid,   0);
    check("rst_step",   out_step,    0);
    check("rst_stall",  stall,       0);
    check("rst_halted", halted,      0);
    check("rst_code",   result_code, 0);
    check("rst_acc",    dut.r_acc,   0);

    // Basic flush: 40 + 40 crosses 64 on the second cycle.
    out_ready = 1'b1;
    steps(8'd20, 8'd20);
    tick();
    check("b_acc40",    dut.r_acc, 40);
    check("b_novalid",  out_valid, 0);
    tick();
    check("b_valid",    out_valid, 1);
    check("b_step80",   out_step,  80);
    check("b_acc0",     dut.r_acc, 0);
    steps(8'd0, 8'd0);
    tick();
    check("b_done",     out_valid, 0);
    check("b_acc_idle", dut.r_acc, 0);

    // Backpressure: request held while steps keep accumulating.
    out_ready = 1'b0;
    steps(8'd40, 8'd40);
    tick();
    check("h_valid", out_valid, 1);
    steps(8'd5, 8'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("h_hold_valid", out_valid, 1);
      check("h_hold_step",  out_step,  80);
    end
    out_ready = 1'b1;
    steps(8'd0, 8'd0);
    tick();
    check("h_hs_valid", out_valid, 0);
    check("h_acc50",    dut.r_acc, 50);
    steps(8'd5, 8'd5);
    tick();
    check("h_acc60",    dut.r_acc, 60);
    check("h_below",    out_valid, 0);
    tick();
    check("h_valid70",  out_valid, 1);
    check("h_step70",   out_step,  70);
    steps(8'd0, 8'd0);
    tick();
    check("h_idle",     out_valid, 0);

    // Overflow stall: 510 per cycle while ISSUE is held.
    out_ready = 1'b0;
    steps(8'd255, 8'd255);
    tick();
    check("s_step510", out_step, 510);
    n = 0;
    while (!stall && n < 200) begin
      tick();
      n++;
    end
    check("s_cycles",  n,         128);
    check("s_stall",   stall,     1);
    check("s_acc",     dut.r_acc, 65280);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s_nowrap", dut.r_acc, 65280);
      check("s_held",   stall,     1);
    end
    out_ready = 1'b1;
    steps(8'd0, 8'd0);
    tick();
    check("s_hs",       out_valid, 0);
    tick();
    check("s_fl_valid", out_valid, 1);
    check("s_fl_step",  out_step,  65280);
    check("s_unstall",  stall,     0);
    tick();
    check("s_idle",     out_valid, 0);

    // Result in ACCUM halts directly with no flush.
    simv_result = 8'h03;
    tick();
    check("r_halted", halted,      1);
    check("r_code3",  result_code, 3);
    check("r_novld",  out_valid,   0);
    check("r_stall",  stall,       1);
    simv_result = 8'h05;
    tick();
    check("r_keep3",  result_code, 3);
    simv_result = 8'h00;
    do_reset();
    check("r_rst_halted", halted,      0);
    check("r_rst_code",   result_code, 0);
    check("r_rst_stall",  stall,       0);

    // Result during ISSUE: pending request completes, then HALT.
    out_ready = 1'b0;
    steps(8'd40, 8'd40);
    tick();
    check("p_valid", out_valid, 1);
    steps(8'd0, 8'd0);
    simv_result = 8'h07;
    tick();
    check("p_halted", halted,      1);
    check("p_code7",  result_code, 7);
    check("p_valid",  out_valid,   1);
    check("p_stall",  stall,       1);
    simv_result = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("p_hold", out_valid, 1);
      check("p_step", out_step,  80);
    end
    out_ready = 1'b1;
    tick();
    check("p_done", out_valid, 0);
    steps(8'd40, 8'd40);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("p_nomore", out_valid, 0);
    end
    check("p_acc0", dut.r_acc, 0);
    steps(8'd0, 8'd0);

    // Handshake and result in the same ISSUE cycle go straight to HALT.
    do_reset();
    out_ready = 1'b0;
    steps(8'd40, 8'd40);
    tick();
    check("x_valid", out_valid, 1);
    steps(8'd0, 8'd0);
    out_ready   = 1'b1;
    simv_result = 8'h09;
    tick();
    check("x_done",  out_valid,   0);
    check("x_code9", result_code, 9);
    check("x_stall", stall,       1);
    simv_result = 8'h00;
    steps(8'd40, 8'd40);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("x_nomore", out_valid, 0);
    end
    steps(8'd0, 8'd0);

    // Reset while ISSUE drops the request.
    do_reset();
    out_ready = 1'b0;
    steps(8'd40, 8'd40);
    tick();
    check("m_valid", out_valid, 1);
    steps(8'd0, 8'd0);
    do_reset();
    check("m_dropped", out_valid, 0);
    check("m_step0",   out_step,  0);

    // Residual single step: idle flush only when the timeout is built in.
    out_ready = 1'b1;
    steps(8'd0, 8'd1);
    tick();
    steps(8'd0, 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
`ifdef DIFFTEST_STEP_TIMEOUT_EN
    check("t_flush", seen,     1);
    check("t_step1", out_step, 1);
`else
    check("t_noflush",  seen,      0);
    check("t_residual", dut.r_acc, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
